input_conditioner: RTL

Parametrised synchroniser, debouncer and edge detector for the board's asynchronous push-buttons and slide switches (run, continue, sw). Sits between the top-level pins and the processor core. Replaces ad-hoc per-button logic with one block of CHANNELS identical lanes. Each lane delivers a clean level plus single-cycle rise/fall strobes.

---
 rtl/input_conditioner.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Per-lane synchroniser, debouncer and edge detector for asynchronous buttons and switches.
// Optional auto-repeat of rise_o while a lane stays high: define INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner #(
   parameter int CHANNELS        = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 64,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_i,
   output logic [CHANNELS-1:0] level_o,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o,
   output logic                any_rise_o
);

   typedef enum logic [1:0] {LOW, PEND_HI, HIGH, PEND_LO} lane_state_t;

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
   localparam int            HOLD_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int            HW        = $clog2(HOLD_MAX) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

   if (CHANNELS < 1 || CHANNELS > 32 || DEBOUNCE_CYCLES < 2 ||
       HOLD_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("input_conditioner: parameter out of range");
   end

   logic [CHANNELS-1:0] s1;
   logic [CHANNELS-1:0] s2;
   logic [CHANNELS-1:0] rise_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1         <= '0;
         s2         <= '0;
         any_rise_o <= 1'b0;
      end else begin
         s1         <= raw_i;
         s2         <= s1;
         any_rise_o <= |rise_nxt;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      lane_state_t   state;
      lane_state_t   state_nxt;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_nxt;
      logic          level_q;
      logic          level_nxt;
      logic          rise_q;
      logic          rise_lane;
      logic          fall_q;
      logic          fall_nxt;
      logic          repeat_strobe;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state   <= LOW;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_q <= level_nxt;
            rise_q  <= rise_lane;
            fall_q  <= fall_nxt;
         end
      end

      // NOTE: defaults assigned first so no path through the case leaves a variable unassigned (no latch).
      always_comb begin
         state_nxt = state;
         case (state)
            LOW:     if (s2[g]) state_nxt = PEND_HI;
            PEND_HI: if (!s2[g]) state_nxt = LOW;
                     else if (cnt == CNT_LAST) state_nxt = HIGH;
            HIGH:    if (!s2[g]) state_nxt = PEND_LO;
            PEND_LO: if (s2[g]) state_nxt = HIGH;
                     else if (cnt == CNT_LAST) state_nxt = LOW;
            default: state_nxt = LOW;
         endcase
      end

      // A disagreeing sample in PEND_* falls through with cnt_nxt at its cleared default.
      always_comb begin
         cnt_nxt   = '0;
         level_nxt = level_q;
         rise_lane = 1'b0;
         fall_nxt  = 1'b0;
         case (state)
            LOW: if (s2[g]) cnt_nxt = CNT_ONE;
            PEND_HI: begin
               if (s2[g]) begin
                  if (cnt == CNT_LAST) begin
                     level_nxt = 1'b1;
                     rise_lane = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CNT_ONE;
                  end
               end
            end
            HIGH: begin
               if (!s2[g]) cnt_nxt = CNT_ONE;
               else        rise_lane = repeat_strobe;
            end
            PEND_LO: begin
               if (!s2[g]) begin
                  if (cnt == CNT_LAST) begin
                     level_nxt = 1'b0;
                     fall_nxt  = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CNT_ONE;
                  end
               end
            end
            default: ;
         endcase
      end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      logic [HW-1:0] hold_cnt;
      logic [HW-1:0] hold_cnt_nxt;
      logic          rep_phase;
      logic          rep_phase_nxt;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
         end else begin
            hold_cnt  <= hold_cnt_nxt;
            rep_phase <= rep_phase_nxt;
         end
      end

      // Every entry to HIGH (acceptance or aborted PEND_LO) restarts the hold interval;
      // outside HIGH-with-s2-high the counter is frozen.
      always_comb begin
         hold_cnt_nxt  = hold_cnt;
         rep_phase_nxt = rep_phase;
         repeat_strobe = 1'b0;
         if (state != HIGH) begin
            if (state_nxt == HIGH) begin
               hold_cnt_nxt  = '0;
               rep_phase_nxt = 1'b0;
            end
         end else if (s2[g]) begin
            if (hold_cnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
               repeat_strobe = 1'b1;
               hold_cnt_nxt  = '0;
               rep_phase_nxt = 1'b1;
            end else begin
               hold_cnt_nxt = hold_cnt + HW'(1);
            end
         end
      end
`else
      assign repeat_strobe = 1'b0;
`endif

      assign rise_nxt[g] = rise_lane;
      assign level_o[g]  = level_q;
      assign rise_o[g]   = rise_q;
      assign fall_o[g]   = fall_q;
   end

endmodule
